fir_mac_core: RTL and testbench
===============================

Name: fir_mac_core

Overview:
- Time-multiplexed FIR datapath with one multiplier, computing y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k].
- Sits directly downstream of the AHB slave register interface:
  - coefficients arrive as single-word register writes;
  - samples arrive on a valid/ready stream.
- Results leave on a valid/ready stream that the AHB read path or the output memory consumes.

Parameters:
- BIT_PREC, 8: signed width of samples and coefficients.
- TAPS, 20: filter length, and the number of MAC cycles per output.
- OUT_SIZE, 2*BIT_PREC+$clog2(TAPS-1) (21 at defaults): signed accumulator and output width.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, synchronous, active-low.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index k.
- coef_wdata  in  BIT_PREC  signed coefficient h[k].
- coef_err  out  1  one-cycle pulse when a write is rejected.
- x_valid  in  1  input sample valid.
- x_ready  out  1  core can accept a sample.
- x_data  in  BIT_PREC  signed input sample.
- y_valid  out  1  output result valid.
- y_ready  in  1  downstream accepts the result.
- y_data  out  OUT_SIZE  signed filter output.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (HRESETn=0 at a rising HCLK):
  - state=IDLE;
  - all TAPS delay-line entries = 0;
  - all coefficients = 0;
  - head=0, acc=0;
  - y_valid=0, y_data=0, coef_err=0, busy=0.
  - Reset asserted mid-MAC or in OUT aborts the computation; no partial result is ever presented.
- States: IDLE -> MAC -> OUT -> IDLE.
- IDLE:
  - x_ready=1.
  - On x_valid&&x_ready:
    - head <= (head+1) mod TAPS;
    - delay[new head] <= x_data;
    - k <= 0, acc <= 0;
    - go to MAC.
- MAC, exactly TAPS cycles:
  - each cycle, acc <= acc + h[k]*delay[(head-k) mod TAPS];
  - k increments;
  - leave for OUT after k=TAPS-1.
- OUT:
  - y_valid=1 and y_data=acc, both held stable until y_ready=1;
  - on y_valid&&y_ready return to IDLE.
- Handshake rules:
  - x_ready=0 in MAC and OUT.
  - y_valid never drops without a handshake.
  - x_ready does not depend combinationally on y_ready.
- Latency: x accepted at edge 0 gives y_valid=1 at edge TAPS+1 (21 at defaults).
- Throughput: one sample per TAPS+2 cycles with y_ready held at 1.
- Arithmetic:
  - product is signed 2*BIT_PREC;
  - it is sign-extended to OUT_SIZE before accumulation;
  - no overflow is possible (|sum| <= TAPS*2^(2*BIT_PREC-2), which fits OUT_SIZE signed);
  - no truncation and no rounding.
- Delay-line wrap: head and read index wrap modulo TAPS, not modulo a power of two.
- Coefficient writes:
  - accepted only in IDLE with coef_addr < TAPS, taking effect from the next cycle;
  - a write in MAC/OUT, or with coef_addr >= TAPS, is ignored and coef_err pulses for 1 cycle.
- Simultaneous coef_we and x accept in IDLE: the write lands first, so the new coefficient is used by that same computation.

Optional Feature:
- Macro: FIR_FLUSH_EN.
- When defined:
  - adds input port flush (1 bit);
  - flush=1 in IDLE zeroes all delay-line entries and head on the next edge;
  - x_ready=0 while flush=1 (flush has priority over a sample);
  - flush is ignored in MAC/OUT;
  - coefficients are unaffected.
- When not defined: no port; the delay line is cleared only by reset.

Decomposition:
- Shared package ahb_fir_pkg gains:
  - COEF_ADDR_WIDTH = $clog2(TAPS);
  - typedef sample_t (signed BIT_PREC);
  - typedef acc_t (signed OUT_SIZE);
  - enum fir_state_t {IDLE, MAC, OUT}.
- BIT_PREC, TAPS and OUT_SIZE remain defined in ahb_fir_pkg.
- One sub-module, fir_mac_unit: registered accumulator with a clear input and a signed multiply-add. The state machine, delay line and coefficient bank stay in the top.

Test Plan:
- Impulse response:
  - write h[k]=k+1 for k=0..19;
  - send x=1 then 20 zeros;
  - required outputs: 1,2,...,20, then 0.
  - First y_valid arrives exactly 21 cycles after the first accept.
- Worst-case magnitude:
  - all h=-128, twenty samples of x=-128;
  - 20th output = 327680;
  - all h=-128, x=+127 ×20 -> 20th output = -325120 (no wrap).
- Backpressure:
  - hold y_ready=0 for 5 cycles in OUT;
  - y_data and y_valid stay stable, x_ready=0;
  - release -> one handshake, back to IDLE, x_ready=1 next cycle.
- Rejected coefficient writes:
  - coef_we during MAC -> coef_err pulse, result unchanged vs golden;
  - coef_addr=20 in IDLE -> coef_err pulse, no coefficient changes.
- Reset mid-MAC:
  - deassert HRESETn at MAC cycle 7;
  - no y_valid;
  - coefficients read back 0, so after reloading h a fresh impulse gives a response identical to the impulse-response test.
- FIR_FLUSH_EN build:
  - fill the delay line with x=5, then flush=1 alongside x_valid=1 in IDLE;
  - no accept that cycle;
  - the next impulse with h=1..20 yields exactly 1..20.

Source files
------------

// File: rtl/ahb_fir_pkg.sv
// Shared types and sizing for the time-multiplexed FIR datapath.
// Everything here is sized from BIT_PREC and TAPS.
package ahb_fir_pkg;

  localparam int BIT_PREC        = 8;
  localparam int TAPS            = 20;
  localparam int OUT_SIZE        = 2*BIT_PREC + $clog2(TAPS-1);
  localparam int COEF_ADDR_WIDTH = $clog2(TAPS);

  typedef logic signed [BIT_PREC-1:0]   sample_t;
  typedef logic signed [2*BIT_PREC-1:0] prod_t;
  typedef logic signed [OUT_SIZE-1:0]   acc_t;
  typedef logic [COEF_ADDR_WIDTH-1:0]   tap_idx_t;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

  localparam tap_idx_t LAST_TAP = tap_idx_t'(TAPS-1);

  // Delay-line pointers wrap at TAPS, which need not be a power of two.
  function automatic tap_idx_t tap_inc(input tap_idx_t i);
    return (i == LAST_TAP) ? '0 : i + 1'b1;
  endfunction

  function automatic tap_idx_t tap_dec(input tap_idx_t i);
    return (i == '0) ? LAST_TAP : i - 1'b1;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate with a synchronous clear.
module fir_mac_unit
  import ahb_fir_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [BIT_PREC-1:0] coef,
  input  logic signed [BIT_PREC-1:0] sample,
  output logic signed [OUT_SIZE-1:0] acc
);

  prod_t prod;

  // The full-width signed product is sign-extended, never truncated.
  assign prod = coef * sample;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + acc_t'(prod);
    end
  end

endmodule

// File: rtl/fir_mac_core.sv
// FIR core: one multiplier time-shared over TAPS cycles per output sample.
// Optional build macro FIR_FLUSH_EN adds a delay-line flush input.
module fir_mac_core
  import ahb_fir_pkg::*;
(
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       coef_we,
  input  logic [COEF_ADDR_WIDTH-1:0] coef_addr,
  input  logic signed [BIT_PREC-1:0] coef_wdata,
  output logic                       coef_err,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic signed [BIT_PREC-1:0] x_data,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic signed [OUT_SIZE-1:0] y_data,
`ifdef FIR_FLUSH_EN
  input  logic                       flush,
`endif
  output logic                       busy
);

  fir_state_t state, next_state;
  tap_idx_t   head, rd_idx, k, next_head;
  sample_t    delay [TAPS];
  sample_t    coef  [TAPS];
  acc_t       acc;
  logic       accept, coef_ok, flush_req;

`ifdef FIR_FLUSH_EN
  assign flush_req = flush && (state == IDLE);
`else
  assign flush_req = 1'b0;
`endif

  assign x_ready   = (state == IDLE) && !flush_req;
  assign accept    = x_valid && x_ready;
  assign next_head = tap_inc(head);
  assign coef_ok   = coef_we && (state == IDLE) && (coef_addr <= LAST_TAP);
  assign y_valid   = (state == OUT);
  assign y_data    = y_valid ? acc : '0;
  assign busy      = (state != IDLE);

  // NOTE: next_state gets its default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)        next_state = MAC;
      MAC:     if (k == LAST_TAP) next_state = OUT;
      OUT:     if (y_ready)       next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= IDLE;
      head     <= '0;
      rd_idx   <= '0;
      k        <= '0;
      coef_err <= 1'b0;
    end else begin
      state    <= next_state;
      coef_err <= coef_we && !coef_ok;
      if (flush_req) begin
        head <= '0;
      end else if (accept) begin
        head   <= next_head;
        rd_idx <= next_head;
        k      <= '0;
      end else if (state == MAC) begin
        rd_idx <= tap_dec(rd_idx);
        k      <= k + 1'b1;
      end
    end
  end

  // NOTE: the delay line and coefficient bank are register arrays that must
  // read as zero after reset, so they are cleared explicitly here.
  always_ff @(posedge HCLK) begin
    if (!HRESETn || flush_req) begin
      for (int i = 0; i < TAPS; i++) delay[i] <= '0;
    end else if (accept) begin
      delay[next_head] <= x_data;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (coef_ok) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  fir_mac_unit u_mac (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .clear  (accept),
    .en     (state == MAC),
    .coef   (coef[k]),
    .sample (delay[rd_idx]),
    .acc    (acc)
  );

endmodule

// File: tb/tb_fir_mac_core.sv
// Self-checking bench for fir_mac_core against a sum-of-products reference.
// Build with FIR_FLUSH_EN defined to cover the flush input as well.
module tb_fir_mac_core;
  import ahb_fir_pkg::*;

  logic                       HCLK = 1'b0;
  logic                       HRESETn = 1'b0;
  logic                       coef_we = 1'b0;
  logic [COEF_ADDR_WIDTH-1:0] coef_addr = '0;
  logic signed [BIT_PREC-1:0] coef_wdata = '0;
  logic                       coef_err;
  logic                       x_valid = 1'b0;
  logic                       x_ready;
  logic signed [BIT_PREC-1:0] x_data = '0;
  logic                       y_valid;
  logic                       y_ready = 1'b1;
  logic signed [OUT_SIZE-1:0] y_data;
  logic                       busy;
`ifdef FIR_FLUSH_EN
  logic                       flush = 1'b0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int h [TAPS];
  int hist [$];

  always #5 HCLK = ~HCLK;

  fir_mac_core dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_data     (x_data),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .y_data     (y_data),
`ifdef FIR_FLUSH_EN
    .flush      (flush),
`endif
    .busy       (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // y[n] = sum h[i]*x[n-i], with samples before the window taken as zero.
  function automatic int model_y();
    int s;
    int idx;
    s = 0;
    for (int i = 0; i < TAPS; i++) begin
      idx = hist.size() - 1 - i;
      if (idx >= 0) s += h[i] * hist[idx];
    end
    return s;
  endfunction

  function automatic void model_clear_coefs();
    for (int i = 0; i < TAPS; i++) h[i] = 0;
  endfunction

  // Called and returns at a negedge with the core idle.
  task automatic write_coef(input int addr, input int data, input bit expect_err);
    coef_we    = 1'b1;
    coef_addr  = COEF_ADDR_WIDTH'(addr);
    coef_wdata = BIT_PREC'(data);
    @(negedge HCLK);
    coef_we = 1'b0;
    check("coef_err_wr", coef_err, expect_err);
    if (!expect_err) h[addr] = data;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1, 1'b0);
  endtask

  // One full transaction: accept, MAC, optional backpressure, handshake.
  task automatic send(input int x, input int bp, input bit mac_wr, input bit acc_wr,
                      input string tag, output logic signed [OUT_SIZE-1:0] y_obs);
    int n;
    int exp_y;
    n = 0;
    while (x_ready !== 1'b1 && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    check($sformatf("%s_x_ready_idle", tag), x_ready, 1);
    if (acc_wr) begin
      coef_we    = 1'b1;
      coef_addr  = '0;
      coef_wdata = 8'sd9;
      h[0]       = 9;
    end
    x_valid = 1'b1;
    x_data  = BIT_PREC'(x);
    hist.push_back(x);
    if (hist.size() > TAPS) void'(hist.pop_front());
    exp_y   = model_y();
    y_ready = (bp == 0);
    @(negedge HCLK);
    x_valid = 1'b0;
    coef_we = 1'b0;
    n = 1;
    if (acc_wr) check($sformatf("%s_coef_err_accept", tag), coef_err, 0);
    if (mac_wr) begin
      coef_we    = 1'b1;
      coef_addr  = 5'd3;
      coef_wdata = 8'sd77;
      @(negedge HCLK);
      n++;
      coef_we = 1'b0;
      check($sformatf("%s_coef_err_mac", tag), coef_err, 1);
      @(negedge HCLK);
      n++;
      check($sformatf("%s_coef_err_drop", tag), coef_err, 0);
    end
    while (y_valid !== 1'b1 && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    check($sformatf("%s_latency", tag), n, TAPS + 1);
    check($sformatf("%s_y_data", tag), y_data, exp_y);
    y_obs = y_data;
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge HCLK);
        check($sformatf("%s_bp_y_valid", tag), y_valid, 1);
        check($sformatf("%s_bp_y_data", tag), y_data, exp_y);
        check($sformatf("%s_bp_x_ready", tag), x_ready, 0);
      end
      y_ready = 1'b1;
    end
    @(negedge HCLK);
    check($sformatf("%s_post_y_valid", tag), y_valid, 0);
    check($sformatf("%s_post_x_ready", tag), x_ready, 1);
  endtask

  initial begin
    logic signed [OUT_SIZE-1:0] y;
    int seen;
    model_clear_coefs();

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data", y_data, 0);
    check("rst_busy", busy, 0);
    check("rst_coef_err", coef_err, 0);
    check("rst_x_ready", x_ready, 1);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Impulse response reproduces the coefficients in order.
    load_ramp();
    send(1, 0, 0, 0, "imp", y);
    check("imp_first", y, 1);
    for (int i = 1; i <= TAPS; i++) begin
      send(0, 0, 0, 0, "imp", y);
      check($sformatf("imp_tap%0d", i), y, (i < TAPS) ? i + 1 : 0);
    end

    // Largest magnitudes in both directions.
    for (int i = 0; i < TAPS; i++) write_coef(i, -128, 1'b0);
    for (int i = 0; i < TAPS; i++) send(-128, 0, 0, 0, "worst_pos", y);
    check("worst_pos_final", y, 327680);
    for (int i = 0; i < TAPS; i++) send(127, 0, 0, 0, "worst_neg", y);
    check("worst_neg_final", y, -325120);

    // Random coefficients, backpressure and rejected writes.
    for (int i = 0; i < TAPS; i++) write_coef(i, int'($urandom_range(0, 255)) - 128, 1'b0);
    send(int'($urandom_range(0, 255)) - 128, 5, 0, 0, "bp", y);
    write_coef(20, 55, 1'b1);
    write_coef(31, -1, 1'b1);
    send(int'($urandom_range(0, 255)) - 128, 0, 1, 0, "mac_wr", y);
    for (int i = 0; i < 25; i++) begin
      if (i % 4 == 1)
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128, 1'b0);
      send(int'($urandom_range(0, 255)) - 128, (i % 6 == 2) ? 2 : 0, 0, (i % 7 == 3), "rand", y);
    end

    // Reset during MAC aborts the result and clears coefficients and history.
    x_valid = 1'b1;
    x_data  = 8'sd3;
    @(negedge HCLK);
    x_valid = 1'b0;
    check("abort_busy", busy, 1);
    repeat (6) @(negedge HCLK);
    HRESETn = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge HCLK);
      if (y_valid !== 1'b0) seen = 1;
    end
    HRESETn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge HCLK);
      if (y_valid !== 1'b0) seen = 1;
    end
    check("abort_no_y_valid", seen, 0);
    check("abort_idle", busy, 0);
    model_clear_coefs();
    hist.delete();
    send(1, 0, 0, 0, "zero_coef", y);
    check("zero_coef_out", y, 0);
    for (int i = 1; i < TAPS; i++) send(0, 0, 0, 0, "zero_coef", y);
    load_ramp();
    for (int i = 0; i <= TAPS; i++) begin
      send((i == 0) ? 1 : 0, 0, 0, 0, "reimp", y);
      check($sformatf("reimp_tap%0d", i), y, (i < TAPS) ? i + 1 : 0);
    end

`ifdef FIR_FLUSH_EN
    for (int i = 0; i < TAPS; i++) send(5, 0, 0, 0, "fill", y);
    flush   = 1'b1;
    x_valid = 1'b1;
    x_data  = 8'sd7;
    #1;
    check("flush_x_ready", x_ready, 0);
    @(negedge HCLK);
    check("flush_no_accept", busy, 0);
    flush   = 1'b0;
    x_valid = 1'b0;
    hist.delete();
    for (int i = 0; i < TAPS; i++) begin
      send((i == 0) ? 1 : 0, 0, 0, 0, "flush_imp", y);
      check($sformatf("flush_tap%0d", i), y, i + 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
